// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC control sequencer: command codes, step states,
// control-vector layout and the hold vector.
package pc_ctrl_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned CTL_W  = 9;

    localparam logic [CODE_W-1:0] CMD_HOLD    = CODE_W'(0);
    localparam logic [CODE_W-1:0] CMD_FETCH   = CODE_W'(1);
    localparam logic [CODE_W-1:0] CMD_LOAD    = CODE_W'(2);
    localparam logic [CODE_W-1:0] CMD_PUSH    = CODE_W'(3);
    localparam logic [CODE_W-1:0] CMD_LOADINC = CODE_W'(4);
    localparam logic [CODE_W-1:0] CMD_BRANCH  = CODE_W'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_A  = 2'd1,
        S_B  = 2'd2,
        S_C  = 2'd3
    } step_t;

    // Bit positions inside the control vector
    localparam int unsigned V_N_IPC   = 0;
    localparam int unsigned V_ADL_PCL = 1;
    localparam int unsigned V_PCL_PCL = 2;
    localparam int unsigned V_PCL_ADL = 3;
    localparam int unsigned V_PCL_DB  = 4;
    localparam int unsigned V_ADH_PCH = 5;
    localparam int unsigned V_PCH_PCH = 6;
    localparam int unsigned V_PCH_ADH = 7;
    localparam int unsigned V_PCH_DB  = 8;

    // Hold: both halves recirculate, no increment, no drive
    localparam logic [CTL_W-1:0] CTL_H = (CTL_W'(1) << V_N_IPC)
                                       | (CTL_W'(1) << V_PCL_PCL)
                                       | (CTL_W'(1) << V_PCH_PCH);

    // Final step of a command given the latched page-crossing flag
    function automatic step_t last_step(input logic [CODE_W-1:0] cmd, input logic fix);
        step_t s;
        case (cmd)
            CMD_LOAD, CMD_PUSH: s = S_B;
            CMD_LOADINC:        s = S_C;
            CMD_BRANCH:         s = fix ? S_B : S_A;
            default:            s = S_A;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pc_ctrl_decode.sv
// Maps (latched command, step, stall) onto the nine PC control strobes.
module pc_ctrl_decode
    import pc_ctrl_pkg::*;
#(
    parameter bit STALL_KEEP_DRIVE = 1'b1
) (
    input  logic [CODE_W-1:0] cmd_latched,
    input  step_t             step,
    input  logic              stall,
    output logic [CTL_W-1:0]  ctl_c
);

    always_comb begin
        ctl_c = CTL_H;
        case (cmd_latched)
            CMD_FETCH: begin
                if (step == S_A) begin
                    ctl_c[V_PCL_ADL] = 1'b1;
                    ctl_c[V_PCH_ADH] = 1'b1;
                    ctl_c[V_N_IPC]   = 1'b0;
                end
            end
            CMD_LOAD, CMD_LOADINC, CMD_BRANCH: begin
                case (step)
                    S_A: begin
                        ctl_c[V_ADL_PCL] = 1'b1;
                        ctl_c[V_PCL_PCL] = 1'b0;
                    end
                    S_B: begin
                        ctl_c[V_ADH_PCH] = 1'b1;
                        ctl_c[V_PCH_PCH] = 1'b0;
                    end
                    S_C: begin
                        if (cmd_latched == CMD_LOADINC) ctl_c[V_N_IPC] = 1'b0;
                    end
                    default: ;
                endcase
            end
            CMD_PUSH: begin
                if (step == S_A) ctl_c[V_PCH_DB] = 1'b1;
                if (step == S_B) ctl_c[V_PCL_DB] = 1'b1;
            end
            default: ;
        endcase

        // Stalled step: no loads, no increment; drives optionally kept
        if (stall) begin
            ctl_c[V_N_IPC]   = 1'b1;
            ctl_c[V_ADL_PCL] = 1'b0;
            ctl_c[V_ADH_PCH] = 1'b0;
            ctl_c[V_PCL_PCL] = 1'b1;
            ctl_c[V_PCH_PCH] = 1'b1;
            if (!STALL_KEEP_DRIVE) begin
                ctl_c[V_PCL_ADL] = 1'b0;
                ctl_c[V_PCL_DB]  = 1'b0;
                ctl_c[V_PCH_ADH] = 1'b0;
                ctl_c[V_PCH_DB]  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// PC command sequencer: accepts commands, steps through their control vectors
// with stall handling, and registers the strobes driving the PC datapath.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned CMD_W            = 3,
    parameter bit          STALL_KEEP_DRIVE = 1'b1
) (
    input  logic             PHI0,
    input  logic             RES,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             fix,
    input  logic             stall,
    output logic             busy,
    output logic             n_IPC,
    output logic             ADL_PCL,
    output logic             PCL_PCL,
    output logic             PCL_ADL,
    output logic             PCL_DB,
    output logic             ADH_PCH,
    output logic             PCH_PCH,
    output logic             PCH_ADH,
    output logic             PCH_DB
);

    step_t              step_q;
    logic [CODE_W-1:0]  cmd_q;
    logic               fix_q;
    logic               full_q;    // current step was shown unstalled
    logic               ready_q;
    logic               busy_q;
    logic [CTL_W-1:0]   ctl_q;

    step_t              step_d;
    logic [CODE_W-1:0]  cmd_d;
    logic               fix_d;
    logic               busy_d;
    logic               ready_d;
    logic               accept_c;
    logic [CODE_W-1:0]  cmd_code_c;
    logic [CTL_W-1:0]   ctl_d;

    assign cmd_code_c = CODE_W'(cmd);
    assign cmd_ready  = ready_q & ~stall & ~RES;
    assign accept_c   = cmd_valid & cmd_ready;

    // Next step: accept, hold a stalled step, finish, or advance
    always_comb begin
        step_d = step_q;
        cmd_d  = cmd_q;
        fix_d  = fix_q;
        if (accept_c) begin
            step_d = S_A;
            cmd_d  = cmd_code_c;
            fix_d  = (cmd_code_c == CMD_BRANCH) ? fix : 1'b0;
        end else if (step_q == IDLE || !full_q) begin
            step_d = step_q;
        end else if (step_q == last_step(cmd_q, fix_q)) begin
            step_d = IDLE;
        end else begin
            case (step_q)
                S_A:     step_d = S_B;
                S_B:     step_d = S_C;
                default: step_d = IDLE;
            endcase
        end

        busy_d  = (step_d != IDLE) && (step_d != last_step(cmd_d, fix_d));
        ready_d = (step_d == IDLE) || ((step_d == last_step(cmd_d, fix_d)) && !stall);
    end

    pc_ctrl_decode #(
        .STALL_KEEP_DRIVE (STALL_KEEP_DRIVE)
    ) u_decode (
        .cmd_latched (cmd_d),
        .step        (step_d),
        .stall       (stall),
        .ctl_c       (ctl_d)
    );

    always_ff @(posedge PHI0) begin
        if (RES) begin
            step_q  <= IDLE;
            cmd_q   <= CMD_HOLD;
            fix_q   <= 1'b0;
            full_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ctl_q   <= CTL_H;
        end else begin
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            fix_q   <= fix_d;
            full_q  <= ~stall;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ctl_q   <= ctl_d;
        end
    end

    assign busy    = busy_q;
    assign n_IPC   = ctl_q[V_N_IPC];
    assign ADL_PCL = ctl_q[V_ADL_PCL];
    assign PCL_PCL = ctl_q[V_PCL_PCL];
    assign PCL_ADL = ctl_q[V_PCL_ADL];
    assign PCL_DB  = ctl_q[V_PCL_DB];
    assign ADH_PCH = ctl_q[V_ADH_PCH];
    assign PCH_PCH = ctl_q[V_PCH_PCH];
    assign PCH_ADH = ctl_q[V_PCH_ADH];
    assign PCH_DB  = ctl_q[V_PCH_DB];

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: hand-computed vectors per cycle, then a random
// command/stall stream checked against the datapath safety invariants.
module tb_pc_ctrl;

    logic       PHI0 = 1'b0;
    logic       RES = 1'b1;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       fix = 1'b0;
    logic       stall = 1'b0;
    logic       busy;
    logic       n_IPC, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB;
    logic       ADH_PCH, PCH_PCH, PCH_ADH, PCH_DB;

    int errors = 0;
    int checks = 0;

    // Bench bit order: {n_IPC,ADL_PCL,PCL_PCL,PCL_ADL,PCL_DB,ADH_PCH,PCH_PCH,PCH_ADH,PCH_DB}
    localparam logic [8:0] V_H  = 9'b1_0_1_0_0_0_1_0_0;
    localparam logic [8:0] V_F  = 9'b0_0_1_1_0_0_1_1_0;
    localparam logic [8:0] V_LA = 9'b1_1_0_0_0_0_1_0_0;
    localparam logic [8:0] V_LB = 9'b1_0_1_0_0_1_0_0_0;
    localparam logic [8:0] V_PA = 9'b1_0_1_0_0_0_1_0_1;
    localparam logic [8:0] V_LC = 9'b0_0_1_0_0_0_1_0_0;

    logic [8:0] ctl_obs;
    assign ctl_obs = {n_IPC, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_PCH, PCH_ADH, PCH_DB};

    pc_ctrl dut (
        .PHI0      (PHI0),
        .RES       (RES),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .fix       (fix),
        .stall     (stall),
        .busy      (busy),
        .n_IPC     (n_IPC),
        .ADL_PCL   (ADL_PCL),
        .PCL_PCL   (PCL_PCL),
        .PCL_ADL   (PCL_ADL),
        .PCL_DB    (PCL_DB),
        .ADH_PCH   (ADH_PCH),
        .PCH_PCH   (PCH_PCH),
        .PCH_ADH   (PCH_ADH),
        .PCH_DB    (PCH_DB)
    );

    always #5 PHI0 = ~PHI0;

    task automatic tick();
        @(negedge PHI0);
    endtask

    task automatic chk(input string tag, input logic [8:0] ev, input logic eb, input logic er);
        logic [10:0] o;
        logic [10:0] e;
        o = {ctl_obs, busy, cmd_ready};
        e = {ev, eb, er};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed={ctl,busy,ready}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic f);
        cmd = c;
        fix = f;
        cmd_valid = 1'b1;
    endtask

    initial begin
        logic inv;

        // Reset
        tick(); tick();
        chk("reset", V_H, 1'b0, 1'b0);
        RES = 1'b0;
        tick();
        chk("post_reset_idle", V_H, 1'b0, 1'b1);

        // FETCH x3 back-to-back
        issue(3'd1, 1'b0);
        tick(); chk("fetch1", V_F, 1'b0, 1'b1);
        tick(); chk("fetch2", V_F, 1'b0, 1'b1);
        tick(); chk("fetch3", V_F, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick(); chk("fetch_idle", V_H, 1'b0, 1'b1);

        // LOAD
        issue(3'd2, 1'b0);
        tick(); chk("load_a", V_LA, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick(); chk("load_b", V_LB, 1'b0, 1'b1);
        tick(); chk("load_idle", V_H, 1'b0, 1'b1);

        // BRANCH without page crossing
        issue(3'd5, 1'b0);
        tick(); chk("branch_nofix_a", V_LA, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick(); chk("branch_nofix_idle", V_H, 1'b0, 1'b1);

        // BRANCH with page crossing; fix dropped after acceptance
        issue(3'd5, 1'b1);
        tick(); chk("branch_fix_a", V_LA, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        fix = 1'b0;
        tick(); chk("branch_fix_b", V_LB, 1'b0, 1'b1);
        tick(); chk("branch_fix_idle", V_H, 1'b0, 1'b1);

        // LOADINC with three stalled cycles on step B
        issue(3'd4, 1'b0);
        tick(); chk("loadinc_a", V_LA, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        stall = 1'b1;
        tick(); chk("loadinc_b_stall1", V_H, 1'b1, 1'b0);
        tick(); chk("loadinc_b_stall2", V_H, 1'b1, 1'b0);
        tick(); chk("loadinc_b_stall3", V_H, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); chk("loadinc_b_reissue", V_LB, 1'b1, 1'b0);
        tick(); chk("loadinc_c", V_LC, 1'b0, 1'b1);
        tick(); chk("loadinc_idle", V_H, 1'b0, 1'b1);

        // PUSH abandoned by reset in step A
        issue(3'd3, 1'b0);
        tick(); chk("push_a", V_PA, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        RES = 1'b1;
        tick(); chk("push_reset", V_H, 1'b0, 1'b0);
        RES = 1'b0;
        tick(); chk("push_after_reset", V_H, 1'b0, 1'b1);
        tick(); chk("push_no_pcl_db", V_H, 1'b0, 1'b1);

        // Reserved codes behave as HOLD
        issue(3'd6, 1'b0);
        tick(); chk("reserved6", V_H, 1'b0, 1'b1);
        issue(3'd7, 1'b0);
        tick(); chk("reserved7", V_H, 1'b0, 1'b1);
        cmd_valid = 1'b0;

        // Stall with a valid command: not accepted
        issue(3'd1, 1'b0);
        stall = 1'b1;
        #1;
        chk("stall_blocks_ready", V_H, 1'b0, 1'b0);
        tick(); chk("stall_no_accept", V_H, 1'b0, 1'b0);
        stall = 1'b0;
        cmd_valid = 1'b0;
        tick(); chk("stall_release_idle", V_H, 1'b0, 1'b1);

        // Random stream with invariant checking
        for (int i = 0; i < 3000; i++) begin
            cmd       = 3'($urandom_range(0, 7));
            cmd_valid = 1'($urandom_range(0, 1));
            fix       = 1'($urandom_range(0, 1));
            stall     = ($urandom_range(0, 3) == 0);
            RES       = ($urandom_range(0, 99) == 0);
            tick();
            inv = !(ADL_PCL & PCL_PCL) && !(ADH_PCH & PCH_PCH)
               && (ADL_PCL ^ PCL_PCL) && (ADH_PCH ^ PCH_PCH)
               && !(PCL_ADL & PCL_DB) && !(PCH_ADH & PCH_DB)
               && (n_IPC || !(ADL_PCL | ADH_PCH))
               && !(cmd_ready && (stall || RES));
            checks++;
            assert (inv === 1'b1) else begin
                errors++;
                $error("FAIL invariant cycle %0d: observed ctl=%b ready=%b expected=consistent", i, ctl_obs, cmd_ready);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
